// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one multi-cycle GCD core
// among NUM_REQ requesters. One job is in flight at a time. Jobs with a zero
// operand are answered directly (gcd = A|B) without starting the core.
//
// Optional feature: define GCD_ARB_TIMEOUT_EN to enable a WAIT-state
// watchdog that aborts the core after TIMEOUT cycles and answers with
// rsp_err=1, rsp_result=0. Without it, WAIT lasts until core_done and
// core_abort/rsp_err are constant 0.
//
// Handshakes: a request transfers on an edge where req_valid[i] & req_ready[i];
// req_ready is a one-hot grant driven only in IDLE, and a requester holds
// req_valid and its operands stable until granted. A response transfers on an
// edge where rsp_valid[id] & rsp_ready[id]; rsp_valid, rsp_result and rsp_err
// stay stable until that edge, and rsp_ready bits of other requesters are
// ignored. The core sees a one-cycle core_start with core_a/core_b held until
// core_done, which is honoured only in WAIT.
module gcd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_err,
  output logic                      core_start,
  output logic [DATA_W-1:0]         core_a,
  output logic [DATA_W-1:0]         core_b,
  input  logic                      core_done,
  input  logic [DATA_W-1:0]         core_result,
  output logic                      core_abort,
  output logic                      busy,
  output logic [1:0]                state_dbg
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Elaboration-time guard on the supported parameter range.
  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1) begin : g_param_check
    $error("gcd_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W:0]     scan_idx;
  logic              grant_found;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [DATA_W-1:0] result_q;
  logic              sel_zero;
  logic              grant_fire;
  logic              accept;
  logic              timeout_hit;

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  // Operand mux for the candidate requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[i*DATA_W +: DATA_W];
        sel_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_zero   = (sel_a == '0) || (sel_b == '0);
  assign grant_fire = (state_q == ST_IDLE) && grant_found;
  assign accept     = (state_q == ST_RESP) && rsp_ready[id_q];

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;

  // WAIT-cycle counter: cleared while issuing, counts every WAIT cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // A done arriving in the timeout cycle wins over the abort.
  assign timeout_hit = (state_q == ST_WAIT) && !core_done &&
                       (to_cnt_q == TO_W'(TIMEOUT));

  // Error flag: set by an abort, cleared by a new job or acceptance.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_q <= 1'b0;
    end else if (accept || grant_fire) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign core_abort = timeout_hit;
  assign rsp_err    = err_q;
`else
  assign timeout_hit = 1'b0;
  assign core_abort  = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          state_d = sel_zero ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_done || timeout_hit) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (accept) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Job datapath: latch operands/id on grant, capture the result, advance rr_ptr.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      id_q     <= '0;
      result_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (grant_fire) begin
        op_a_q <= sel_a;
        op_b_q <= sel_b;
        id_q   <= grant_idx;
        if (sel_zero) begin
          result_q <= sel_a | sel_b;
        end
      end
      if (state_q == ST_WAIT) begin
        if (core_done) begin
          result_q <= core_result;
        end else if (timeout_hit) begin
          result_q <= '0;
        end
      end
      if (accept) begin
        rr_ptr_q <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
      end
    end
  end

  assign req_ready  = grant_fire ? (NUM_REQ'(1) << grant_idx) : '0;
  assign rsp_valid  = (state_q == ST_RESP) ? (NUM_REQ'(1) << id_q) : '0;
  assign rsp_result = result_q;
  assign core_start = (state_q == ST_ISSUE);
  assign core_a     = op_a_q;
  assign core_b     = op_b_q;
  assign busy       = (state_q != ST_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin scheduler that shares one multi-cycle GCD datapath core among `NUM_REQ` requesters. It accepts one operand pair at a time, starts the core, waits for completion, and returns the result to the originating requester through a valid/ready response channel. It sits between the requester-side blocks and the single GCD core, which has its own start/done handshake. It also handles zero operands without using the core and can optionally abort hung jobs.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, from 2 to 16.
- `DATA_W`, 32: operand and result width.
- `TIMEOUT`, 1024: WAIT-state cycle limit. Only used with the watchdog enabled.

Ports:
- `sys_clk`  in  1  clock. All logic is on the rising edge.
- `sys_rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  one-hot grant/accept.
- `req_a`  in  NUM_REQ*DATA_W  flattened operand A. Requester i uses slice [i*DATA_W +: DATA_W].
- `req_b`  in  NUM_REQ*DATA_W  flattened operand B, same layout.
- `rsp_valid`  out  NUM_REQ  one-hot response valid.
- `rsp_ready`  in  NUM_REQ  per-requester response accept.
- `rsp_result`  out  DATA_W  GCD result, shared by all requesters.
- `rsp_err`  out  1  set when the job timed out.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_a`, `core_b`  out  DATA_W  core operands, held stable from start until done.
- `core_done`  in  1  core completion pulse.
- `core_result`  in  DATA_W  core result, valid while `core_done` is high.
- `core_abort`  out  1  one-cycle abort pulse to the core.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP. Binary-encoded; RTL must not rely on a particular encoding.
- **IDLE:**
  - Round-robin selection: starting at `rr_ptr`, pick the first index i with `req_valid[i]` set, wrapping modulo NUM_REQ.
  - In the same cycle, `req_ready[i]` is driven combinationally high.
  - On that edge the block latches A, B and the id i.
  - If A==0 or B==0: set result = A|B (so gcd(0,0)=0) and go to RESP. The core is never started.
  - Otherwise go to ISSUE.
  - With no `req_valid` bits set, stay in IDLE.
- **ISSUE:** `core_start`=1 for exactly one cycle, with `core_a`/`core_b` equal to the latched operands. Then go to WAIT.
- **WAIT:** on `core_done`, latch `core_result` into `rsp_result` and go to RESP.
  - `core_done` in any other state is ignored.
- **RESP:** `rsp_valid[id]`=1, with `rsp_result` and `rsp_err` held stable.
  - On `rsp_valid[id] & rsp_ready[id]`: go to IDLE and set `rr_ptr`=(id+1) mod NUM_REQ.
  - `rsp_ready` bits of other requesters are ignored.
- `req_ready` is zero outside IDLE. A requester must hold `req_valid` and its operands stable until it sees `req_ready`.
- At most one job is in flight. There is no request queue.
- Operand width is unsigned DATA_W. The block performs no arithmetic on operands besides the zero check and the OR.

## Timing
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_err`=0, `core_start`=0, `core_a`=`core_b`=0, `core_abort`=0, `busy`=0, `rr_ptr`=0, state=IDLE.
- **Reset mid-job:** discard the job without issuing a response or `core_abort`. The core is reset by the same `sys_rst`.
- **Core path latency:** grant edge T, `core_start` high in cycle T+1. If `core_done` is sampled at edge D, `rsp_valid` is high from cycle D+1.
- **Bypass latency:** `rsp_valid` high in cycle T+1.
- **Back-to-back:** response accepted at edge R gives IDLE in cycle R+1. A new grant is possible in cycle R+1.
- **Response hold:** `rsp_valid` is held indefinitely while `rsp_ready` is low (backpressure).
- **Simultaneous requests:** exactly one grant per IDLE cycle, chosen by `rr_ptr` priority. Two requesters that stay valid continuously alternate grants.

## Configuration
- **Macro:** `GCD_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without `core_done`: pulse `core_abort` for 1 cycle, set `rsp_result`=0 and `rsp_err`=1, and go to RESP.
  - If `core_done` and the timeout occur in the same cycle, `core_done` wins (`rsp_err`=0).
  - `rsp_err` clears on response acceptance.
- **Not defined:** no counter. WAIT lasts until `core_done`. `core_abort` and `rsp_err` are tied to 0.

## Test plan
- **Single request:** requester 0 sends A=48, B=18; core model with 5-cycle latency. Expect `core_start` 1 cycle after grant, then `rsp_valid`=4'b0001 with `rsp_result`=6 and `rsp_err`=0.
- **Zero bypass:** requester 2 sends A=0, B=35. Expect no `core_start`, `rsp_result`=35 one cycle after grant. Then A=0, B=0 → `rsp_result`=0.
- **Fairness:** all 4 requesters hold `req_valid` high, with `rsp_ready` high. Expect grant order 0,1,2,3,0. After reset the first grant goes to 0.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles during a job with A=21, B=14. Expect `rsp_valid` and `rsp_result`=7 stable throughout, `req_ready` all zero, and no second grant until acceptance.
- **Timeout (macro defined, TIMEOUT=8):** core never asserts done. Expect `core_abort` pulse 8 cycles after entering WAIT, then `rsp_err`=1 and `rsp_result`=0. Repeat with `core_done` on cycle 8 → `rsp_err`=0.
- **Reset mid-WAIT:** assert `sys_rst` for 1 cycle during WAIT. Expect all outputs at reset values next cycle, no response issued, and the next grant to requester 0.
